fastdac_rng_wr_arbiter: RTL and testbench

//  Owns the single write port of the DAC1 RNG DPRAM (fastdac_rng_wen/addr/din_int) and shares it between
//  two requesters: the host register bank (random-address single-word writes) and a 128-bit AXI-stream RNG

---
 rtl/fastdac_rng_wr_arbiter.sv | 146 ++++++++++++++
 tb/tb_fastdac_rng_wr_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fastdac_rng_wr_arbiter.sv
// Single write-port owner for the DAC1 RNG DPRAM: serialises host register writes and an
// AXI-stream RNG feed (WORDS words per beat) into a circular address ring.
module fastdac_rng_wr_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WORDS  = 4
) (
  input  logic                    tx_core_clk,
  input  logic                    tx_core_reset,
  input  logic                    host_wen_i,
  input  logic [ADDR_W-1:0]       host_addr_i,
  input  logic [DATA_W-1:0]       host_din_i,
  output logic                    host_busy_o,
  output logic                    host_drop_o,
  input  logic                    stream_en_i,
  input  logic                    ptr_rst_i,
  input  logic [ADDR_W-1:0]       max_addr_i,
  input  logic [WORDS*DATA_W-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic                    fastdac_rng_wen_int,
  output logic [ADDR_W-1:0]       fastdac_rng_addr_int,
  output logic [DATA_W-1:0]       fastdac_rng_din_int,
  output logic                    wrap_o,
  output logic [31:0]             words_written_o
);

  localparam int unsigned CntW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StUnpack, StHost} state_e;

  state_e            state;
  logic [CntW-1:0]   cnt;
  logic [DATA_W-1:0] beat_words [WORDS];
  logic              hold_valid;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_din;
  logic              drop;
  logic [ADDR_W-1:0] wr_ptr;

  logic              last_word;
  logic              accept;
  logic              host_issue;
  logic              stream_issue;
  logic              ptr_at_end;
  logic [CntW-1:0]   nxt_idx;
  logic [DATA_W-1:0] stream_word;

  // cnt is the index of the word currently on the write port, so the next word is cnt+1.
  assign last_word    = (state == StUnpack) && (cnt == CntW'(WORDS - 1));
  assign s_axis_tready = ~tx_core_reset & stream_en_i & ~hold_valid &
                         ((state == StIdle) | last_word);
  assign accept       = s_axis_tvalid & s_axis_tready;
  assign host_issue   = hold_valid & ((state == StIdle) | last_word);
  assign stream_issue = accept | ((state == StUnpack) & ~last_word);
  assign nxt_idx      = cnt + 1'b1;
  assign stream_word  = accept ? s_axis_tdata[DATA_W-1:0] : beat_words[nxt_idx];
  // All-ones also wraps so a ring shrunk below the live pointer still comes back to 0.
  assign ptr_at_end   = (wr_ptr == max_addr_i) || (&wr_ptr);

  assign host_busy_o  = hold_valid;
  assign host_drop_o  = drop;

  always_ff @(posedge tx_core_clk) begin
    if (tx_core_reset) begin
      state                <= StIdle;
      cnt                  <= '0;
      hold_valid           <= 1'b0;
      hold_addr            <= '0;
      hold_din             <= '0;
      drop                 <= 1'b0;
      wr_ptr               <= '0;
      fastdac_rng_wen_int  <= 1'b0;
      fastdac_rng_addr_int <= '0;
      fastdac_rng_din_int  <= '0;
      wrap_o               <= 1'b0;
      words_written_o      <= '0;
    end else begin
      fastdac_rng_wen_int <= 1'b0;
      wrap_o              <= 1'b0;

      if (host_issue) begin
        fastdac_rng_wen_int  <= 1'b1;
        fastdac_rng_addr_int <= hold_addr;
        fastdac_rng_din_int  <= hold_din;
      end else if (stream_issue) begin
        fastdac_rng_wen_int  <= 1'b1;
        fastdac_rng_addr_int <= wr_ptr;
        fastdac_rng_din_int  <= stream_word;
        wrap_o               <= ptr_at_end & ~ptr_rst_i;
        words_written_o      <= words_written_o + 32'd1;
      end

      if (ptr_rst_i) begin
        wr_ptr <= '0;
      end else if (stream_issue) begin
        wr_ptr <= ptr_at_end ? '0 : wr_ptr + 1'b1;
      end

      // A strobe in the same cycle the held word issues refills the register.
      if (host_wen_i && (!hold_valid || host_issue)) begin
        hold_valid <= 1'b1;
        hold_addr  <= host_addr_i;
        hold_din   <= host_din_i;
      end else if (host_issue) begin
        hold_valid <= 1'b0;
      end
      if (host_wen_i && hold_valid && !host_issue) begin
        drop <= 1'b1;
      end

      if (accept) begin
        for (int k = 0; k < WORDS; k++) begin
          beat_words[k] <= s_axis_tdata[k*DATA_W +: DATA_W];
        end
      end

      unique case (state)
        StIdle: begin
          if (host_issue) begin
            state <= StHost;
          end else if (accept) begin
            state <= StUnpack;
            cnt   <= '0;
          end
        end
        StUnpack: begin
          if (last_word) begin
            if (host_issue) begin
              state <= StHost;
            end else if (accept) begin
              cnt <= '0;
            end else begin
              state <= StIdle;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StHost:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fastdac_rng_wr_arbiter.sv
// Self-checking bench for fastdac_rng_wr_arbiter: a write scoreboard fed at stimulus time,
// a host-write vector table, and hand-timed sequences for priority, pointer reset and reset.
module tb_fastdac_rng_wr_arbiter;

  localparam int WORDS = 4;

  logic          clk = 1'b0;
  logic          tx_core_reset;
  logic          host_wen_i;
  logic [11:0]   host_addr_i;
  logic [31:0]   host_din_i;
  logic          host_busy_o;
  logic          host_drop_o;
  logic          stream_en_i;
  logic          ptr_rst_i;
  logic [11:0]   max_addr_i;
  logic [127:0]  s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          fastdac_rng_wen_int;
  logic [11:0]   fastdac_rng_addr_int;
  logic [31:0]   fastdac_rng_din_int;
  logic          wrap_o;
  logic [31:0]   words_written_o;

  fastdac_rng_wr_arbiter dut (
    .tx_core_clk         (clk),
    .tx_core_reset       (tx_core_reset),
    .host_wen_i          (host_wen_i),
    .host_addr_i         (host_addr_i),
    .host_din_i          (host_din_i),
    .host_busy_o         (host_busy_o),
    .host_drop_o         (host_drop_o),
    .stream_en_i         (stream_en_i),
    .ptr_rst_i           (ptr_rst_i),
    .max_addr_i          (max_addr_i),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tready       (s_axis_tready),
    .fastdac_rng_wen_int (fastdac_rng_wen_int),
    .fastdac_rng_addr_int(fastdac_rng_addr_int),
    .fastdac_rng_din_int (fastdac_rng_din_int),
    .wrap_o              (wrap_o),
    .words_written_o     (words_written_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] din;
    logic        wrap;
  } wr_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] din;
    logic [11:0] exp_addr;
    logic [31:0] exp_din;
  } host_vec_t;

  wr_t         sb[$];
  host_vec_t   hv[3];
  int          total = 0;
  int          bad = 0;
  logic [11:0] model_ptr = '0;
  int          model_words = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [127:0] mk_beat(logic [7:0] tag);
    logic [127:0] d;
    for (int k = 0; k < WORDS; k++) d[k*32 +: 32] = {tag, 24'(k + 1)};
    return d;
  endfunction

  function automatic void push_words(logic [127:0] data, int n);
    wr_t e;
    for (int k = 0; k < n; k++) begin
      e.addr = model_ptr;
      e.din  = data[k*32 +: 32];
      e.wrap = (model_ptr == max_addr_i) || (model_ptr == 12'hFFF);
      sb.push_back(e);
      model_ptr = e.wrap ? 12'h000 : model_ptr + 12'h001;
      model_words++;
    end
  endfunction

  function automatic void push_raw(logic [11:0] a, logic [31:0] d, logic w);
    wr_t e;
    e.addr = a;
    e.din  = d;
    e.wrap = w;
    sb.push_back(e);
  endfunction

  // Scoreboard: every DPRAM write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (fastdac_rng_wen_int === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wen: got addr %0h din %0h want no write",
                 fastdac_rng_addr_int, fastdac_rng_din_int);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", fastdac_rng_addr_int, e.addr);
        chk("wr_din", fastdac_rng_din_int, e.din);
        chk("wr_wrap", wrap_o, e.wrap);
      end
    end else if (wrap_o === 1'b1) begin
      chk("wrap_without_wen", wrap_o, 1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_beat(logic [127:0] data, int npush, output int waits);
    s_axis_tdata  = data;
    s_axis_tvalid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!s_axis_tready && waits < 64) begin
      waits++;
      @(negedge clk);
    end
    if (!s_axis_tready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got tready 0 want 1 within 64 cycles");
    end else begin
      push_words(data, npush);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(int n, logic [7:0] tag, output int stalls);
    int w;
    stalls = 0;
    for (int b = 0; b < n; b++) begin
      accept_beat(mk_beat(tag + 8'(b)), WORDS, w);
      stalls += w;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic pulse_ptr_rst();
    ptr_rst_i = 1'b1;
    step();
    ptr_rst_i = 1'b0;
    model_ptr = '0;
  endtask

  initial begin
    int st;
    logic [127:0] d;

    hv[0] = '{addr: 12'h123, din: 32'hDEADBEEF, exp_addr: 12'h123, exp_din: 32'hDEADBEEF};
    hv[1] = '{addr: 12'h000, din: 32'h00000001, exp_addr: 12'h000, exp_din: 32'h00000001};
    hv[2] = '{addr: 12'hFFF, din: 32'hA5A55A5A, exp_addr: 12'hFFF, exp_din: 32'hA5A55A5A};

    tx_core_reset = 1'b1;
    host_wen_i    = 1'b0;
    host_addr_i   = '0;
    host_din_i    = '0;
    stream_en_i   = 1'b1;
    ptr_rst_i     = 1'b0;
    max_addr_i    = 12'd7;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_wen", fastdac_rng_wen_int, 1'b0);
    chk("rst_addr", fastdac_rng_addr_int, 12'h000);
    chk("rst_din", fastdac_rng_din_int, 32'h0);
    chk("rst_busy", host_busy_o, 1'b0);
    chk("rst_drop", host_drop_o, 1'b0);
    chk("rst_wrap", wrap_o, 1'b0);
    chk("rst_words", words_written_o, 32'h0);
    chk("rst_tready", s_axis_tready, 1'b0);
    s_axis_tvalid = 1'b0;
    step();
    tx_core_reset = 1'b0;
    step();

    // Three back-to-back beats into an 8-word ring.
    send_beats(3, 8'h00, st);
    chk("t1_stalls", st, 6);
    drain();
    chk("t1_words", words_written_o, 32'(model_words));

    // Host writes from idle: busy for one cycle, write two cycles after the strobe.
    for (int i = 0; i < 3; i++) begin
      host_wen_i  = 1'b1;
      host_addr_i = hv[i].addr;
      host_din_i  = hv[i].din;
      push_raw(hv[i].exp_addr, hv[i].exp_din, 1'b0);
      step();
      host_wen_i = 1'b0;
      @(negedge clk);
      chk("t2_busy", host_busy_o, 1'b1);
      chk("t2_wen_early", fastdac_rng_wen_int, 1'b0);
      step();
      @(negedge clk);
      chk("t2_wen", fastdac_rng_wen_int, 1'b1);
      chk("t2_addr", fastdac_rng_addr_int, hv[i].exp_addr);
      chk("t2_din", fastdac_rng_din_int, hv[i].exp_din);
      chk("t2_busy_clr", host_busy_o, 1'b0);
      step();
    end
    drain();

    // Host strobe at cnt=1: beat completes, host word next, then the next beat.
    accept_beat(mk_beat(8'h30), WORDS, st);
    s_axis_tdata = mk_beat(8'h40);
    step();
    host_wen_i  = 1'b1;
    host_addr_i = 12'h0AB;
    host_din_i  = 32'h0BADF00D;
    push_raw(12'h0AB, 32'h0BADF00D, 1'b0);
    step();
    host_wen_i = 1'b0;
    @(negedge clk);
    chk("t3_busy", host_busy_o, 1'b1);
    step();
    @(negedge clk);
    chk("t3_tready_blocked", s_axis_tready, 1'b0);
    step();
    @(negedge clk);
    chk("t3_tready_host", s_axis_tready, 1'b0);
    chk("t3_host_addr", fastdac_rng_addr_int, 12'h0AB);
    step();
    @(negedge clk);
    chk("t3_tready_after", s_axis_tready, 1'b1);
    push_words(s_axis_tdata, WORDS);
    step();
    s_axis_tvalid = 1'b0;
    drain();

    // Two host strobes one cycle apart while streaming: second is dropped.
    accept_beat(mk_beat(8'h50), WORDS, st);
    s_axis_tvalid = 1'b0;
    host_wen_i  = 1'b1;
    host_addr_i = 12'h010;
    host_din_i  = 32'h11111111;
    push_raw(12'h010, 32'h11111111, 1'b0);
    step();
    host_addr_i = 12'h020;
    host_din_i  = 32'h22222222;
    step();
    host_wen_i = 1'b0;
    @(negedge clk);
    chk("t4_drop", host_drop_o, 1'b1);
    drain();
    chk("t4_drop_sticky", host_drop_o, 1'b1);
    chk("t4_busy", host_busy_o, 1'b0);

    // ptr_rst coincident with the write at address 5.
    pulse_ptr_rst();
    max_addr_i = 12'd7;
    send_beats(1, 8'h60, st);
    drain();
    d = mk_beat(8'h70);
    accept_beat(d, 0, st);
    s_axis_tvalid = 1'b0;
    push_raw(12'd4, d[31:0], 1'b0);
    push_raw(12'd5, d[63:32], 1'b0);
    push_raw(12'd0, d[95:64], 1'b0);
    push_raw(12'd1, d[127:96], 1'b0);
    model_words += 4;
    ptr_rst_i = 1'b1;
    step();
    ptr_rst_i = 1'b0;
    model_ptr = 12'd2;
    drain();
    chk("t5_words", words_written_o, 32'(model_words));

    // max_addr=0: every word goes to address 0 and wraps.
    pulse_ptr_rst();
    max_addr_i = 12'd0;
    send_beats(1, 8'h78, st);
    drain();
    max_addr_i = 12'd7;

    // Reset at cnt=2: fourth word never written, everything cleared.
    accept_beat(mk_beat(8'h80), 3, st);
    step();
    step();
    tx_core_reset = 1'b1;
    @(negedge clk);
    chk("t6_tready_rst", s_axis_tready, 1'b0);
    step();
    @(negedge clk);
    chk("t6_wen", fastdac_rng_wen_int, 1'b0);
    chk("t6_tready_idle_rst", s_axis_tready, 1'b0);
    chk("t6_words", words_written_o, 32'h0);
    chk("t6_drop", host_drop_o, 1'b0);
    chk("t6_addr", fastdac_rng_addr_int, 12'h000);
    s_axis_tvalid = 1'b0;
    step();
    tx_core_reset = 1'b0;
    model_ptr   = '0;
    model_words = 0;
    chk("t6_sb_empty", sb.size(), 0);
    step();
    send_beats(1, 8'h90, st);
    drain();
    chk("t6_words_after", words_written_o, 32'(model_words));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish by 200000");
    $fatal(1);
  end

endmodule
